delay_line: RTL and testbench



---
 rtl/delay_line.sv | 149 ++++++++++++++
 tb/tb_delay_line.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// ============================================================================
//  Module   : delay_line
//  Purpose  : Qualified multi-bit delay line with a runtime-programmable delay
//             of 0..MAX_DELAY cycles. It is built on a circular buffer. Output
//             stays invalid until enough fresh samples have been written since
//             reset or since the last delay load.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             ce        - advance enable (only with DELAY_LINE_CE_EN defined)
//             din       - input sample            din_vld  - input qualifier
//             dly_load  - strobe, samples dly_sel dly_sel  - requested delay
//             dout      - delayed sample (0 when invalid)
//             dout_vld  - delayed qualifier       primed   - fill >= cur_dly
//             cur_dly   - active delay            dly_err  - clamped-load pulse
//  Config   : DELAY_LINE_CE_EN adds the ce port. When ce is low, the line
//             holds its state and the outputs are forced invalid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line #(
    parameter  int WIDTH         = 8,
    parameter  int MAX_DELAY     = 16,
    parameter  int DEFAULT_DELAY = 4,
    localparam int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DELAY_LINE_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             dly_load,
    input  logic [DW-1:0]    dly_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             primed,
    output logic [DW-1:0]    cur_dly,
    output logic             dly_err
);

    localparam int          PW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [DW-1:0] c_max_dly = DW'(MAX_DELAY);
    localparam logic [DW:0]   c_depth   = (DW+1)'(MAX_DELAY);

    // Each slot holds {vld, data}. Contents are not reset; the fill counter
    // keeps stale slots from ever reaching the output.
    logic [WIDTH:0]   mem_q [MAX_DELAY];

    logic [PW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [DW-1:0]    fill_q,    fill_d;
    logic [DW-1:0]    cur_dly_q, cur_dly_d;
    logic             dly_err_q, dly_err_d;

    logic             w_adv;
    logic             w_sel_big;
    logic [DW:0]      w_rd_sum;
    logic [PW-1:0]    w_rd_addr;
    logic [WIDTH:0]   w_rd_word;
    logic             w_primed;
    logic             w_vld;
    logic [WIDTH-1:0] w_data;

`ifdef DELAY_LINE_CE_EN
    assign w_adv = ce;
`else
    assign w_adv = 1'b1;
`endif

    assign w_sel_big = (dly_sel > c_max_dly);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        cur_dly_d = cur_dly_q;
        dly_err_d = 1'b0;

        if (w_adv) begin
            wr_ptr_d = (wr_ptr_q == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (fill_q != c_max_dly) begin
                fill_d = fill_q + DW'(1);
            end
        end

        // A load discards the buffer history. The sample written on the same
        // edge is the first one that counts, if a sample is written at all.
        if (dly_load) begin
            cur_dly_d = w_sel_big ? c_max_dly : dly_sel;
            dly_err_d = w_sel_big;
            fill_d    = w_adv ? DW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            cur_dly_q <= DW'(DEFAULT_DELAY);
            dly_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            cur_dly_q <= cur_dly_d;
            dly_err_q <= dly_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_adv) begin
            mem_q[wr_ptr_q] <= {din_vld, din};
        end
    end

    // ------------------------------------------------------------------
    // Read side. The address is (wr_ptr - cur_dly) mod MAX_DELAY. It is
    // computed as wr_ptr + MAX_DELAY - cur_dly so the value stays
    // non-negative. At most one subtraction then brings it back into range.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_sum  = (DW+1)'(wr_ptr_q) + c_depth - {1'b0, cur_dly_q};
        w_rd_addr = (w_rd_sum >= c_depth) ? PW'(w_rd_sum - c_depth) : PW'(w_rd_sum);
        w_rd_word = mem_q[w_rd_addr];
        w_primed  = (fill_q >= cur_dly_q);

        if (cur_dly_q == '0) begin
            w_vld  = din_vld;
            w_data = din;
        end else begin
            w_vld  = w_primed & w_rd_word[WIDTH];
            w_data = w_rd_word[WIDTH-1:0];
        end

        // No sample moves on a stalled cycle, so nothing is valid.
        w_vld = w_vld & w_adv;
    end

    assign dout     = w_vld ? w_data : '0;
    assign dout_vld = w_vld;
    assign primed   = w_primed;
    assign cur_dly  = cur_dly_q;
    assign dly_err  = dly_err_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_line.sv
// ============================================================================
//  Module   : tb_delay_line
//  Purpose  : Self-checking bench for delay_line. It uses a directed vector
//             table, hand sequences for the maximum-delay and clamp corners,
//             and randomized traffic scored against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_line;

    localparam int WIDTH         = 8;
    localparam int MAX_DELAY     = 16;
    localparam int DEFAULT_DELAY = 4;
    localparam int DW            = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             ce_r;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             dly_load;
    logic [DW-1:0]    dly_sel;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             primed;
    logic [DW-1:0]    cur_dly;
    logic             dly_err;

    always #5 clk = ~clk;

    delay_line #(
        .WIDTH        (WIDTH),
        .MAX_DELAY    (MAX_DELAY),
        .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef DELAY_LINE_CE_EN
        .ce      (ce_r),
`endif
        .din     (din),
        .din_vld (din_vld),
        .dly_load(dly_load),
        .dly_sel (dly_sel),
        .dout    (dout),
        .dout_vld(dout_vld),
        .primed  (primed),
        .cur_dly (cur_dly),
        .dly_err (dly_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. Samples written since the last reset or load are held
    // oldest-first. Delay D selects the sample written D edges ago.
    logic [WIDTH:0] mq[$];
    int             m_cur   = DEFAULT_DELAY;
    bit             m_err   = 1'b0;
    bit             m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle. Drive inputs, check the outputs at the falling edge,
    // then advance the model on the rising edge.
    task automatic step(input bit r, input bit c, input logic [WIDTH-1:0] d, input bit v,
                        input bit ld, input int sel,
                        output logic [WIDTH-1:0] o_d, output logic o_v);
        logic [WIDTH-1:0] e_dout;
        bit               e_vld;
        bit               e_primed;
        int               n;
        rst      = r;
        ce_r     = c;
        din      = d;
        din_vld  = v;
        dly_load = ld;
        dly_sel  = DW'(sel);
        @(negedge clk);
        o_d = dout;
        o_v = dout_vld;
        n   = mq.size();
        e_dout = '0;
        if (m_cur == 0) begin
            e_primed = 1'b1;
            e_vld    = v;
            if (e_vld) e_dout = d;
        end else begin
            e_primed = (n >= m_cur);
            e_vld    = e_primed && mq[n - m_cur][WIDTH];
            if (e_vld) e_dout = mq[n - m_cur][WIDTH-1:0];
        end
        if (!c) begin
            e_vld  = 1'b0;
            e_dout = '0;
        end
        if (m_known) begin
            chk("dout",     32'(dout),     32'(e_dout));
            chk("dout_vld", 32'(dout_vld), 32'(e_vld));
            chk("primed",   32'(primed),   32'(e_primed));
            chk("cur_dly",  32'(cur_dly),  32'(m_cur));
            chk("dly_err",  32'(dly_err),  32'(m_err));
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_cur   = DEFAULT_DELAY;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            m_err = ld && (sel > MAX_DELAY);
            if (ld) begin
                mq.delete();
                m_cur = (sel > MAX_DELAY) ? MAX_DELAY : sel;
            end
            if (c) begin
                mq.push_back({v, d});
                if (mq.size() > MAX_DELAY) void'(mq.pop_front());
            end
        end
        #1;
    endtask

    typedef struct {
        bit               r;
        logic [WIDTH-1:0] d;
        bit               v;
        bit               ld;
        int               sel;
        logic [WIDTH-1:0] ed;
        bit               ev;
    } vec_t;

    vec_t tv[22];

    initial begin
        logic [WIDTH-1:0] od;
        logic             ov;
        bit               rr, cc, vv, ll;

        rst = 1'b1; ce_r = 1'b1; din = '0; din_vld = 1'b0; dly_load = 1'b0; dly_sel = '0;

        // Directed table: reset stream at DEFAULT_DELAY=4, a pass-through load,
        // then the valid pattern 1,0,1,1 at delay 3, then an oversized load.
        tv[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0};
        for (int k = 1; k <= 9; k++) begin
            tv[k] = '{1'b0, 8'(k), 1'b1, 1'b0, 0, (k >= 5) ? 8'(k - 4) : 8'h00, (k >= 5)};
        end
        tv[10] = '{1'b0, 8'h10, 1'b1, 1'b1, 0,  8'h06, 1'b1};
        tv[11] = '{1'b0, 8'h21, 1'b1, 1'b0, 0,  8'h21, 1'b1};
        tv[12] = '{1'b0, 8'h22, 1'b0, 1'b0, 0,  8'h00, 1'b0};
        tv[13] = '{1'b0, 8'h23, 1'b1, 1'b1, 3,  8'h23, 1'b1};
        tv[14] = '{1'b0, 8'h31, 1'b1, 1'b0, 0,  8'h00, 1'b0};
        tv[15] = '{1'b0, 8'h32, 1'b0, 1'b0, 0,  8'h00, 1'b0};
        tv[16] = '{1'b0, 8'h33, 1'b1, 1'b0, 0,  8'h23, 1'b1};
        tv[17] = '{1'b0, 8'h34, 1'b1, 1'b0, 0,  8'h31, 1'b1};
        tv[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  8'h00, 1'b0};
        tv[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  8'h33, 1'b1};
        tv[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  8'h34, 1'b1};
        tv[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 20, 8'h00, 1'b0};

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, 1'b0, 1'b0, 0, od, ov);
        chk("rst_cur_dly", 32'(cur_dly),  32'(DEFAULT_DELAY));
        chk("rst_primed",  32'(primed),   32'd0);
        chk("rst_vld",     32'(dout_vld), 32'd0);
        chk("rst_err",     32'(dly_err),  32'd0);

        for (int i = 0; i < 22; i++) begin
            step(tv[i].r, 1'b1, tv[i].d, tv[i].v, tv[i].ld, tv[i].sel, od, ov);
            chk($sformatf("tv%0d_vld", i),  32'(ov), 32'(tv[i].ev));
            chk($sformatf("tv%0d_dout", i), 32'(od), 32'(tv[i].ed));
        end

        // The oversized load clamps to MAX_DELAY and pulses dly_err once.
        chk("clamp_cur", 32'(cur_dly), 32'(MAX_DELAY));
        chk("clamp_err", 32'(dly_err), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5, od, ov);
        chk("legal_err", 32'(dly_err), 32'd0);
        chk("legal_cur", 32'(cur_dly), 32'd5);

        // Maximum delay in mid-stream. The output stays silent for 15 cycles,
        // then replays the load-edge sample gap-free past the pointer wrap.
        step(1'b0, 1'b1, 8'h40, 1'b1, 1'b1, MAX_DELAY, od, ov);
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1, 8'(8'h40 + k), 1'b1, 1'b0, 0, od, ov);
            chk($sformatf("max_vld%0d", k), 32'(ov), (k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("max_dout%0d", k), 32'(od), (k >= 16) ? 32'(8'h40 + k - 16) : 32'd0);
        end
        // Reloading the same delay flushes the history.
        step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, MAX_DELAY, od, ov);
        step(1'b0, 1'b1, 8'h9a, 1'b1, 1'b0, 0, od, ov);
        chk("flush_vld", 32'(ov), 32'd0);

`ifdef DELAY_LINE_CE_EN
        // Reset while stalled, then run at D=2 with ce toggling each cycle.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, od, ov);
        chk("ce_rst_cur", 32'(cur_dly), 32'(DEFAULT_DELAY));
        step(1'b0, 1'b1, 8'h50, 1'b1, 1'b1, 2, od, ov);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, (k % 2) == 0, 8'(8'h50 + k), 1'b1, 1'b0, 0, od, ov);
        end
`endif

        // Randomized traffic scored against the model.
        for (int i = 0; i < 500; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            ll = ($urandom_range(0, 9) == 0);
            vv = $urandom_range(0, 1);
            cc = 1'b1;
`ifdef DELAY_LINE_CE_EN
            cc = ($urandom_range(0, 3) != 0);
`endif
            step(rr, cc, 8'($urandom), vv, ll, $urandom_range(0, 20), od, ov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
